// File: rtl/demux_16w_1_to_2.sv
// -----------------------------------------------------------------------------
// demux_16w_1_to_2
//
// Buffered 1-to-2 demultiplexer. It takes words from one producer over a
// valid/ready handshake and steers each word to channel X (S=1) or channel Y
// (S=0). This matches the select polarity of the 16-bit 2-to-1 datapath mux.
//
// Each channel has its own 2-entry FIFO. A consumer that stalls only blocks
// words selected to its own channel. Traffic for the other channel keeps
// flowing.
//
// An accepted word shows up on its channel one cycle later. There is no
// combinational path from D to X or Y.
//
// Ports
//   Clock     in   rising-edge clock
//   Resetn    in   asynchronous active-low reset
//   D         in   [W-1:0] input word
//   S         in   route select sampled with D (1 -> X, 0 -> Y)
//   In_valid  in   D/S valid
//   In_ready  out  block can accept D this cycle (depends on S and state only)
//   X         out  [W-1:0] channel X head word
//   X_valid   out  X holds a valid word
//   X_ready   in   X consumer accepts
//   Y         out  [W-1:0] channel Y head word
//   Y_valid   out  Y holds a valid word
//   Y_ready   in   Y consumer accepts
//
// Optional feature, enabled by defining the macro DEMUX_COUNT_EN:
//   Cnt_X     out  [15:0] saturating count of words popped on X
//   Cnt_Y     out  [15:0] saturating count of words popped on Y
//   Cnt_clr   in   synchronous clear of both counters (wins over increment)
// -----------------------------------------------------------------------------
module demux_16w_1_to_2 #(
  parameter int W = 16
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic [W-1:0] D,
  input  logic         S,
  input  logic         In_valid,
  output logic         In_ready,
  output logic [W-1:0] X,
  output logic         X_valid,
  input  logic         X_ready,
  output logic [W-1:0] Y,
  output logic         Y_valid,
  input  logic         Y_ready
`ifdef DEMUX_COUNT_EN
  ,
  output logic [15:0]  Cnt_X,
  output logic [15:0]  Cnt_Y,
  input  logic         Cnt_clr
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } fifo_state_e;

  // Index 0 is channel X and index 1 is channel Y in every per-channel vector.
  localparam int CH_X = 0;
  localparam int CH_Y = 1;

  logic         ready_en_q;
  logic         accept;
  logic [1:0]   push;
  logic [1:0]   pop;
  logic [1:0]   full;
  logic [1:0]   valid;
  logic [1:0]   ch_ready;
  logic [W-1:0] head [2];

  assign ch_ready = {Y_ready, X_ready};

  // ready_en_q holds In_ready low while Resetn is asserted. It lets In_ready
  // rise only after the first clock edge once reset has been released.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      ready_en_q <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
    end
  end

  // In_ready looks only at the selected channel's registered fullness. A full
  // channel blocks only the words addressed to it. X_ready and Y_ready are
  // deliberately left out, so there is no combinational path from a consumer
  // back to the producer.
  assign In_ready  = ready_en_q & (S ? ~full[CH_X] : ~full[CH_Y]);
  assign accept    = In_valid & In_ready;
  assign push[CH_X] = accept &  S;
  assign push[CH_Y] = accept & ~S;

  // ---------------------------------------------------------------------------
  // Per-channel 2-entry FIFO. Occupancy is tracked by a three-state FSM.
  // The two storage entries are addressed by 1-bit pointers that wrap
  // naturally.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_ch
    fifo_state_e  state_q, state_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [2];

    assign valid[gi] = (state_q != ST_EMPTY);
    assign full[gi]  = (state_q == ST_TWO);
    assign pop[gi]   = valid[gi] & ch_ready[gi];
    assign head[gi]  = mem_q[rd_ptr_q];

    always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q ^ push[gi];
      rd_ptr_d = rd_ptr_q ^ pop[gi];
      case (state_q)
        ST_EMPTY: begin
          // Nothing can be popped from an empty channel.
          if (push[gi]) begin
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (push[gi] && !pop[gi]) begin
            state_d = ST_TWO;
          end else if (pop[gi] && !push[gi]) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          // In_ready keeps push low here, so only a pop can change state.
          if (pop[gi]) begin
            state_d = ST_ONE;
          end
        end
        default: begin
          state_d  = ST_EMPTY;
          wr_ptr_d = 1'b0;
          rd_ptr_d = 1'b0;
        end
      endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
        state_q  <= ST_EMPTY;
        wr_ptr_q <= 1'b0;
        rd_ptr_q <= 1'b0;
      end else begin
        state_q  <= state_d;
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
      end
    end

    // Storage entries are cleared on reset so that X and Y read as zero while
    // the block is held in reset.
    for (genvar gj = 0; gj < 2; gj++) begin : g_entry
      always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
          mem_q[gj] <= '0;
        end else if (push[gi] && (wr_ptr_q == 1'(gj))) begin
          mem_q[gj] <= D;
        end
      end
    end
  end

  assign X       = head[CH_X];
  assign X_valid = valid[CH_X];
  assign Y       = head[CH_Y];
  assign Y_valid = valid[CH_Y];

`ifdef DEMUX_COUNT_EN
  // ---------------------------------------------------------------------------
  // Saturating pop counters, one per channel.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (Cnt_clr) begin
        cnt_d = 16'h0000;
      end else if (pop[gi] && (cnt_q != 16'hFFFF)) begin
        cnt_d = cnt_q + 16'd1;
      end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
        cnt_q <= 16'h0000;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

  assign Cnt_X = g_cnt[CH_X].cnt_q;
  assign Cnt_Y = g_cnt[CH_Y].cnt_q;
`endif

endmodule
